bist_engine: RTL

//  Parametrised on-chip BIST engine that wraps a sequential CUT.
//  - bistmode=0: primary inputs go straight to the CUT and CUT outputs go straight to po.
//  - bistmode=1: an LFSR drives the CUT inputs and a MISR compacts the CUT outputs.
//  - At the end of a BIST run the MISR signature is compared with GOLDEN_SIG; the result
//    is reported on bistdone/bistpass.
//  - Successor to the fixed 35-in/49-out controller. New: generic widths, pattern count,
//    CUT init flush, mid-run abort, signature readout.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/bist_misr.sv | 34 +++
 rtl/bist_engine.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared FSM state type and width-generic LFSR/MISR helper functions
package bist_pkg;

    localparam int MAX_W = 256;

    typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} state_e;

    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] taps, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int k = 1; k < MAX_W; k++) r[k] = (k < w) ? s[k-1] : 1'b0;
        r[0] = ^(s & taps);
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] fold_po(input logic [MAX_W-1:0] po, input int po_w, input int misr_w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int j = 0; j < MAX_W; j++) if (j < po_w) r[j % misr_w] = r[j % misr_w] ^ po[j];
        return r;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register folding a wide response into MISR_W bits
module bist_misr
    import bist_pkg::*;
#(
    parameter int               MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_TAPS = 16'hB400,
    parameter int               PO_W      = 49
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PO_W-1:0]   din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q, sig_d;

    // next signature: clear wins over capture, otherwise hold
    always_comb begin
        sig_d = clr ? '0
              : en  ? (MISR_W'(lfsr_next(MAX_W'(sig_q), MAX_W'(MISR_TAPS), MISR_W)) ^ MISR_W'(fold_po(MAX_W'(din), PO_W, MISR_W)))
              : sig_q;
    end

    // signature register
    always_ff @(posedge clk) begin
        if (rst) sig_q <= '0;
        else     sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_engine.sv
// bist_engine: LFSR/MISR BIST controller wrapping a sequential CUT with functional pass-through
module bist_engine
    import bist_pkg::*;
#(
    parameter int                PI_W       = 35,
    parameter int                PO_W       = 49,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED       = 16'h0001,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_TAPS  = 16'hB400,
    parameter int                N_PATTERNS = 2000,
    parameter int                INIT_CYC   = 2,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bistmode,
    input  logic [PI_W-1:0]   pi,
    output logic [PO_W-1:0]   po,
    output logic [PI_W-1:0]   cut_pi,
    output logic              cut_rst,
    input  logic [PO_W-1:0]   cut_po,
    output logic              bistdone,
    output logic              bistpass,
    output logic [MISR_W-1:0] sig_out
);

    localparam int IC_W = $clog2(INIT_CYC + 1);
    localparam int RC_W = $clog2(N_PATTERNS + 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(INIT_CYC - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(N_PATTERNS);

    state_e            state_q, state_d;
    logic [IC_W-1:0]   ic_q, ic_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, prev_q, prev_d;
    logic              pass_q, pass_d;
    logic              misr_clr, misr_en;
    logic [MISR_W-1:0] sig;

    function automatic logic [PI_W-1:0] pattern(input logic [LFSR_W-1:0] s);
        logic [PI_W-1:0] p;
        for (int j = 0; j < PI_W; j++)
            p[j] = (j < LFSR_W) ? s[j % LFSR_W] : s[j % LFSR_W] ^ s[(j / LFSR_W) % LFSR_W];
        return p;
    endfunction

    // FSM next state, pattern generator stepping and MISR control; bistmode low aborts any active run
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        prev_d   = prev_q;
        pass_d   = 1'b0;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        ic_d     = (state_q == INIT) ? ((ic_q == IC_LAST) ? ic_q : ic_q + IC_W'(1)) : '0;
        rc_d     = (state_q == RUN) ? ((rc_q == RC_LAST) ? rc_q : rc_q + RC_W'(1)) : '0;
        case (state_q)
            IDLE: if (bistmode) state_d = INIT;
            INIT: begin
                misr_clr = 1'b1;
                lfsr_d   = SEED;
                state_d  = !bistmode ? IDLE : (ic_q == IC_LAST) ? RUN : INIT;
            end
            RUN: begin
                if (!bistmode) state_d = IDLE;
                else begin
                    misr_en = (rc_q != '0);
                    if (rc_q != RC_LAST) begin
                        lfsr_d = LFSR_W'(lfsr_next(MAX_W'(lfsr_q), MAX_W'(LFSR_TAPS), LFSR_W));
                        prev_d = lfsr_q;
                    end else state_d = CMP;
                end
            end
            CMP: begin
                state_d = bistmode ? DONE : IDLE;
                pass_d  = bistmode && (sig == GOLDEN_SIG);
            end
            DONE: begin
                state_d = bistmode ? DONE : IDLE;
                pass_d  = bistmode && pass_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters, LFSR and verdict registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ic_q    <= '0;
            rc_q    <= '0;
            lfsr_q  <= SEED;
            prev_q  <= SEED;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            lfsr_q  <= lfsr_d;
            prev_q  <= prev_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(.MISR_W(MISR_W), .MISR_TAPS(MISR_TAPS), .PO_W(PO_W)) u_misr (
        .clk(clk),
        .rst(rst),
        .clr(misr_clr),
        .en (misr_en),
        .din(cut_po),
        .sig(sig)
    );

    // the final RUN cycle replays the previous pattern because the LFSR has already advanced
    assign cut_pi   = (state_q != RUN) ? pi : pattern((rc_q == RC_LAST) ? prev_q : lfsr_q);
    assign cut_rst  = rst | (state_q == INIT);
    assign po       = cut_po;
    assign bistdone = (state_q == DONE);
    assign bistpass = pass_q;
    assign sig_out  = sig;

endmodule
